reg_file_mp: RTL and testbench

//  Parametrised multi-port register file for the datapath; successor of the 16x8 two-read/one-write file.
//  N combinational read ports, two prioritised write ports, optional write-to-read bypass.

---
 rtl/reg_file_mp_if.sv | 36 +++
 rtl/reg_file_mp.sv | 95 +++++++++
 tb/tb_reg_file_mp.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// Operand/write/control bundle between decode, ALU and the multi-port register file.
// The master drives addresses, write data and control; the slave returns operands and status.
interface reg_file_mp_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned D     = 4,
  parameter int unsigned NREAD = 2
);
  logic                 Clear;
  logic                 Busy;
  logic [NREAD*D-1:0]   RdAddr;
  logic [NREAD*W-1:0]   RdData;
  logic                 WrEn0;
  logic [D-1:0]         WrAddr0;
  logic [W-1:0]         WrData0;
  logic                 WrEn1;
  logic [D-1:0]         WrAddr1;
  logic [W-1:0]         WrData1;
  logic                 CarryWrite;
  logic                 CarryOutValue;
  logic                 CarryInValue;
  logic [W-1:0]         BranchAmount;
  logic                 BranchDirection;
  logic                 WrConflict;

  modport master (
    output Clear, RdAddr, WrEn0, WrAddr0, WrData0, WrEn1, WrAddr1, WrData1,
           CarryWrite, CarryOutValue,
    input  Busy, RdData, CarryInValue, BranchAmount, BranchDirection, WrConflict
  );

  modport slave (
    input  Clear, RdAddr, WrEn0, WrAddr0, WrData0, WrEn1, WrAddr1, WrData1,
           CarryWrite, CarryOutValue,
    output Busy, RdData, CarryInValue, BranchAmount, BranchDirection, WrConflict
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: N combinational read ports, two prioritised write ports,
// gated carry-flag update, sequential clear sweep and a sticky write-conflict flag.
module reg_file_mp #(
  parameter int unsigned W          = 8,
  parameter int unsigned D          = 4,
  parameter int unsigned NREAD      = 2,
  parameter bit          BYPASS     = 1'b1,
  parameter int unsigned BITS_REG   = 1,
  parameter int unsigned CARRY_BIT  = 0,
  parameter int unsigned BRANCH_REG = 2,
  parameter int unsigned ACC_REG    = 0
) (
  input  logic          CLK,
  input  logic          Init_n,
  reg_file_mp_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << D;
  localparam logic [D-1:0] LAST_IDX   = D'(DEPTH - 1);
  localparam logic [D-1:0] BITS_IDX   = D'(BITS_REG);
  localparam logic [D-1:0] BRANCH_IDX = D'(BRANCH_REG);
  localparam logic [D-1:0] ACC_IDX    = D'(ACC_REG);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state_q, state_d;
  logic [D-1:0]    idx_q, idx_d;
  logic            conflict_q, conflict_d;
  logic [W-1:0]    regs_q [DEPTH];
  logic [W-1:0]    regs_d [DEPTH];
  logic [NREAD*W-1:0] rd_data;

  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      conflict_q <= 1'b0;
      regs_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      conflict_q <= conflict_d;
      regs_q     <= regs_d;
    end
  end

  // Next state: port writes, then carry merge, in IDLE; one register zeroed per cycle in SWEEP.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    conflict_d = conflict_q;
    regs_d     = regs_q;
    case (state_q)
      IDLE: begin
        if (bus.WrEn0) regs_d[bus.WrAddr0] = bus.WrData0;
        if (bus.WrEn1) regs_d[bus.WrAddr1] = bus.WrData1;
        if (bus.WrEn0 && bus.WrEn1 && (bus.WrAddr0 == bus.WrAddr1)) conflict_d = 1'b1;
        if (bus.CarryWrite) regs_d[BITS_IDX][CARRY_BIT] = bus.CarryOutValue;
        if (bus.Clear) begin
          state_d    = SWEEP;
          idx_d      = '0;
          conflict_d = 1'b0;
        end
      end
      SWEEP: begin
        regs_d[idx_q] = '0;
        idx_d         = D'(idx_q + 1'b1);
        if (idx_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read ports: port 1 write outranks port 0; forwarding only while writes are accepted.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(NREAD); i++) begin
      rd_data[i*W +: W] = regs_q[bus.RdAddr[i*D +: D]];
      if (BYPASS && (state_q == IDLE)) begin
        if (bus.WrEn1 && (bus.WrAddr1 == bus.RdAddr[i*D +: D]))
          rd_data[i*W +: W] = bus.WrData1;
        else if (bus.WrEn0 && (bus.WrAddr0 == bus.RdAddr[i*D +: D]))
          rd_data[i*W +: W] = bus.WrData0;
      end
    end
  end

  assign bus.RdData          = rd_data;
  assign bus.Busy            = (state_q == SWEEP);
  assign bus.WrConflict      = conflict_q;
  assign bus.CarryInValue    = regs_q[BITS_IDX][CARRY_BIT];
  assign bus.BranchAmount    = regs_q[BRANCH_IDX];
  assign bus.BranchDirection = regs_q[ACC_IDX][0];

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed-vector bench for reg_file_mp: bypass, conflict, carry merge, sweep and reset behaviour.
module tb_reg_file_mp;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam int unsigned NREAD = 2;

  logic CLK;
  logic Init_n;
  int   n_vec;
  int   n_err;
  int   busy_cycles;

  reg_file_mp_if #(.W(W), .D(D), .NREAD(NREAD)) bus ();
  reg_file_mp_if #(.W(W), .D(D), .NREAD(NREAD)) bus_nb ();

  reg_file_mp #(.W(W), .D(D), .NREAD(NREAD), .BYPASS(1'b1)) u_dut (
    .CLK(CLK), .Init_n(Init_n), .bus(bus)
  );

  reg_file_mp #(.W(W), .D(D), .NREAD(NREAD), .BYPASS(1'b0)) u_dut_nb (
    .CLK(CLK), .Init_n(Init_n), .bus(bus_nb)
  );

  // Non-forwarding copy sees exactly the same stimulus.
  assign bus_nb.Clear         = bus.Clear;
  assign bus_nb.RdAddr        = bus.RdAddr;
  assign bus_nb.WrEn0         = bus.WrEn0;
  assign bus_nb.WrAddr0       = bus.WrAddr0;
  assign bus_nb.WrData0       = bus.WrData0;
  assign bus_nb.WrEn1         = bus.WrEn1;
  assign bus_nb.WrAddr1       = bus.WrAddr1;
  assign bus_nb.WrData1       = bus.WrData1;
  assign bus_nb.CarryWrite    = bus.CarryWrite;
  assign bus_nb.CarryOutValue = bus.CarryOutValue;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Clear = 1'b0; bus.WrEn0 = 1'b0; bus.WrEn1 = 1'b0; bus.CarryWrite = 1'b0;
    bus.CarryOutValue = 1'b0;
  endtask

  task automatic rd0(input logic [3:0] a, input logic [7:0] exp, input string tag);
    bus.RdAddr[3:0] = a;
    #1;
    chk(tag, 32'(bus.RdData[7:0]), 32'(exp));
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    Init_n = 1'b0;
    idle_inputs();
    bus.RdAddr = '0; bus.WrAddr0 = '0; bus.WrData0 = '0; bus.WrAddr1 = '0; bus.WrData1 = '0;
    tick(); tick();
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_conflict", 32'(bus.WrConflict), 0);
    chk("rst_rd", 32'(bus.RdData), 0);
    chk("rst_branch", 32'(bus.BranchAmount), 0);
    #2 Init_n = 1'b1;
    tick();

    // Same-cycle forwarding vs. stored-only read
    bus.WrEn0 = 1'b1; bus.WrAddr0 = 4'd3; bus.WrData0 = 8'h5A; bus.RdAddr[3:0] = 4'd3;
    #1;
    chk("bypass_fwd", 32'(bus.RdData[7:0]), 32'h5A);
    chk("nobypass_old", 32'(bus_nb.RdData[7:0]), 32'h00);
    tick();
    bus.WrEn0 = 1'b0;
    #1;
    chk("nobypass_new", 32'(bus_nb.RdData[7:0]), 32'h5A);
    chk("bypass_stored", 32'(bus.RdData[7:0]), 32'h5A);

    // Conflict on address 5: port 1 wins, flag sticks
    bus.WrEn0 = 1'b1; bus.WrAddr0 = 4'd5; bus.WrData0 = 8'h11;
    bus.WrEn1 = 1'b1; bus.WrAddr1 = 4'd5; bus.WrData1 = 8'h22;
    bus.RdAddr[7:4] = 4'd5;
    #1;
    chk("bypass_prio", 32'(bus.RdData[15:8]), 32'h22);
    tick();
    idle_inputs();
    #1;
    chk("conflict_val", 32'(bus.RdData[15:8]), 32'h22);
    chk("conflict_flag", 32'(bus.WrConflict), 1);
    bus.WrEn0 = 1'b1; bus.WrAddr0 = 4'd6; bus.WrData0 = 8'h66;
    tick();
    idle_inputs();
    chk("conflict_sticky", 32'(bus.WrConflict), 1);
    rd0(4'd6, 8'h66, "wr_r6");

    // Derived outputs lag the write edge
    bus.WrEn1 = 1'b1; bus.WrAddr1 = 4'd2; bus.WrData1 = 8'h37;
    bus.WrEn0 = 1'b1; bus.WrAddr0 = 4'd0; bus.WrData0 = 8'h01;
    #1;
    chk("branch_pre", 32'(bus.BranchAmount), 0);
    chk("dir_pre", 32'(bus.BranchDirection), 0);
    tick();
    idle_inputs();
    chk("branch_amt", 32'(bus.BranchAmount), 32'h37);
    chk("branch_dir", 32'(bus.BranchDirection), 1);

    // Carry merged over a same-cycle port write to the flag register
    bus.WrEn0 = 1'b1; bus.WrAddr0 = 4'd1; bus.WrData0 = 8'hFE;
    bus.CarryWrite = 1'b1; bus.CarryOutValue = 1'b1;
    tick();
    idle_inputs();
    rd0(4'd1, 8'hFF, "carry_merge");
    chk("carry_in", 32'(bus.CarryInValue), 1);
    tick();
    chk("carry_hold", 32'(bus.CarryInValue), 1);
    bus.CarryWrite = 1'b1; bus.CarryOutValue = 1'b0;
    tick();
    idle_inputs();
    chk("carry_clr", 32'(bus.CarryInValue), 0);
    rd0(4'd1, 8'hFE, "carry_clr_reg");

    // Fill, then sweep; writes and Clear during the sweep must be ignored
    for (int a = 0; a < 16; a++) begin
      bus.WrEn0 = 1'b1; bus.WrAddr0 = 4'(a); bus.WrData0 = 8'hFF;
      tick();
    end
    idle_inputs();
    rd0(4'd15, 8'hFF, "fill_r15");
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    chk("sweep_busy", 32'(bus.Busy), 1);
    chk("sweep_conflict", 32'(bus.WrConflict), 0);
    busy_cycles = 0;
    while (bus.Busy && busy_cycles < 40) begin
      bus.WrEn0 = 1'b1; bus.WrAddr0 = 4'(busy_cycles); bus.WrData0 = 8'h77;
      bus.CarryWrite = 1'b1; bus.CarryOutValue = 1'b1;
      bus.Clear = (busy_cycles == 5);
      busy_cycles++;
      tick();
    end
    idle_inputs();
    chk("sweep_len", 32'(busy_cycles), 16);
    for (int a = 0; a < 16; a++) rd0(4'(a), 8'h00, "sweep_zero");
    chk("sweep_carry", 32'(bus.CarryInValue), 0);

    bus.WrEn0 = 1'b1; bus.WrAddr0 = 4'd9; bus.WrData0 = 8'h42;
    tick();
    idle_inputs();
    rd0(4'd9, 8'h42, "post_sweep_wr");

    // Reset in the middle of a sweep
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    repeat (7) tick();
    chk("mid_busy", 32'(bus.Busy), 1);
    rd0(4'd9, 8'h42, "mid_r9");
    #1 Init_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.Busy), 0);
    chk("abort_r9", 32'(bus.RdData[7:0]), 0);
    #2 Init_n = 1'b1;
    tick();
    chk("abort_idle", 32'(bus.Busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
